// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: streams feature/weight pairs from two SRAM read ports
// into a free-running MAC. The result is the accum delta over one job.
// The MAC cannot be cleared, so the accum value is snapshotted at job start.
module mac_operand_feeder #(
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 8,
    parameter int ACC_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              feat_rd_en,
    output logic [ADDR_W-1:0] feat_rd_addr,
    input  logic [7:0]        feat_rd_data,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    input  logic [7:0]        wgt_rd_data,
    output logic [7:0]        mac_feature,
    output logic [7:0]        mac_weight,
    input  logic [ACC_W-1:0]  mac_accum,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    input  logic              res_ready
);

    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_rd_v;
    logic [CNT_W-1:0]  r_drain;
    logic [ACC_W-1:0]  r_base;
    logic [ACC_W-1:0]  r_res;
    logic              r_res_valid;

    logic              w_last_addr;
    logic              w_last_drain;

    assign w_last_addr  = (r_addr == (r_len - ADDR_W'(1)));
    assign w_last_drain = (r_drain == CNT_W'(LATENCY));

    // Job sequencing: issue len reads, drain SRAM + MAC latency, hold result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_addr      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_v      <= 1'b0;
            r_drain     <= '0;
            r_base      <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_rd_v <= r_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_len   <= len;
                            r_base  <= mac_accum;
                            r_addr  <= '0;
                            r_rd_en <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_res       <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_last_addr) begin
                        r_rd_en <= 1'b0;
                        r_addr  <= '0;
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_last_drain) begin
                        r_res       <= mac_accum - r_base;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_drain <= r_drain + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outside valid data cycles the MAC sees 0*0, so accum stays put.
    always_comb begin
        mac_feature = r_rd_v ? feat_rd_data : '0;
        mac_weight  = r_rd_v ? wgt_rd_data  : '0;
    end

    assign busy         = (r_state != S_IDLE);
    assign feat_rd_en   = r_rd_en;
    assign feat_rd_addr = r_addr;
    assign wgt_rd_en    = r_rd_en;
    assign wgt_rd_addr  = r_addr;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: SRAM and MAC environment models plus
// directed and random jobs; expected results are plain dot products.
module tb_mac_operand_feeder;

    localparam int LAT = 3;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        feat_rd_en;
    logic [7:0]  feat_rd_addr;
    logic [7:0]  feat_rd_data;
    logic        wgt_rd_en;
    logic [7:0]  wgt_rd_addr;
    logic [7:0]  wgt_rd_data;
    logic [7:0]  mac_feature;
    logic [7:0]  mac_weight;
    logic [31:0] mac_accum;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;

    logic [7:0]  feat_mem [256];
    logic [7:0]  wgt_mem  [256];
    logic [15:0] pipe [LAT-1];
    logic        preload;
    logic [31:0] preload_val;

    int total = 0;
    int bad   = 0;

    mac_operand_feeder #(.LATENCY(LAT), .ADDR_W(8), .ACC_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .feat_rd_en   (feat_rd_en),
        .feat_rd_addr (feat_rd_addr),
        .feat_rd_data (feat_rd_data),
        .wgt_rd_en    (wgt_rd_en),
        .wgt_rd_addr  (wgt_rd_addr),
        .wgt_rd_data  (wgt_rd_data),
        .mac_feature  (mac_feature),
        .mac_weight   (mac_weight),
        .mac_accum    (mac_accum),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            feat_rd_data <= '0;
            wgt_rd_data  <= '0;
        end else begin
            feat_rd_data <= feat_rd_en ? feat_mem[feat_rd_addr] : 8'($urandom);
            wgt_rd_data  <= wgt_rd_en  ? wgt_mem[wgt_rd_addr]   : 8'($urandom);
        end
    end

    // MAC model: product visible in accum LAT cycles after it is presented.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
            mac_accum <= '0;
        end else begin
            pipe[0] <= 16'(mac_feature) * 16'(mac_weight);
            for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
            mac_accum <= preload ? preload_val : mac_accum + 32'(pipe[LAT-2]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dot(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s = s + 32'(feat_mem[i]) * 32'(wgt_mem[i]);
        return s;
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    // Returns at the negedge of the first HOLD cycle.
    task automatic run_job(input int n, input logic [31:0] exp);
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("issue_en", feat_rd_en, 1);
            check("issue_addr", feat_rd_addr, i);
            check("wgt_en_eq", wgt_rd_en, feat_rd_en);
            check("wgt_addr_eq", wgt_rd_addr, feat_rd_addr);
            check("issue_busy", busy, 1);
            if (i > 0) begin
                check("feed_feat", mac_feature, feat_mem[i-1]);
                check("feed_wgt", mac_weight, wgt_mem[i-1]);
            end else begin
                check("feed_feat0", mac_feature, 0);
            end
            @(negedge clk);
        end
        if (n > 0) begin
            for (int d = 0; d < LAT + 1; d++) begin
                check("drain_en", feat_rd_en, 0);
                check("drain_valid", res_valid, 0);
                check("drain_busy", busy, 1);
                check("drain_feat", mac_feature, (d == 0) ? feat_mem[n-1] : 8'h00);
                check("drain_wgt", mac_weight, (d == 0) ? wgt_mem[n-1] : 8'h00);
                @(negedge clk);
            end
        end
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, exp);
        check("hold_busy", busy, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_valid", res_valid, 0);
        check("post_busy", busy, 0);
    endtask

    task automatic load_basic();
        feat_mem[0] = 1; feat_mem[1] = 2; feat_mem[2] = 3; feat_mem[3] = 4;
        wgt_mem[0]  = 5; wgt_mem[1]  = 6; wgt_mem[2]  = 7; wgt_mem[3]  = 8;
    endtask

    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; len = '0; res_ready = 1'b0;
        preload = 1'b0; preload_val = '0;
        for (int i = 0; i < 256; i++) begin
            feat_mem[i] = 8'($urandom);
            wgt_mem[i]  = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_en", feat_rd_en, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_feat", mac_feature, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic job: 1*5+2*6+3*7+4*8
        load_basic();
        run_job(4, 32'd70);
        check("basic_ref", dot(4), 32'd70);
        handshake();

        // Back-to-back with nonzero base
        feat_mem[0] = 10; feat_mem[1] = 3; wgt_mem[0] = 2; wgt_mem[1] = 4;
        run_job(2, 32'd32);
        handshake();

        // Backpressure with ignored start during HOLD
        load_basic();
        run_job(4, 32'd70);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 70);
            check("bp_noread", feat_rd_en, 0);
            start = (k == 2);
            len   = 8'd3;
            @(negedge clk);
        end
        start = 1'b0;
        handshake();
        check("bp_idle_en", feat_rd_en, 0);
        @(negedge clk);
        check("bp_still_idle", busy, 0);
        check("bp_no_read", feat_rd_en, 0);

        // Zero length
        run_job(0, 32'd0);
        check("zl_en", feat_rd_en, 0);
        check("zl_feat", mac_feature, 0);
        check("zl_wgt", mac_weight, 0);
        handshake();

        // Wrap-around of accum
        preload = 1'b1; preload_val = 32'hFFFF_FFF0;
        @(negedge clk);
        preload = 1'b0;
        check("wrap_preload", mac_accum, 32'hFFFF_FFF0);
        feat_mem[0] = 4; feat_mem[1] = 4; wgt_mem[0] = 4; wgt_mem[1] = 4;
        run_job(2, 32'h20);
        check("wrap_accum", mac_accum, 32'h10);
        handshake();

        // Random jobs
        for (int j = 0; j < 6; j++) begin
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                feat_mem[i] = 8'($urandom);
                wgt_mem[i]  = 8'($urandom);
            end
            run_job(n, dot(n));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end

        // Reset mid-ISSUE
        start = 1'b1; len = 8'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_en", feat_rd_en, 0);
        check("mr_addr", feat_rd_addr, 0);
        check("mr_valid", res_valid, 0);
        check("mr_data", res_data, 0);
        check("mr_feat", mac_feature, 0);
        check("mr_wgt", mac_weight, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        load_basic();
        run_job(4, 32'd70);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
